// File: rtl/gpu_pkg.sv
// Shared frame-buffer geometry, widths and FSM encoding for the 2D fill hardware.
// Also hosts the constant-multiply helper used to form row base addresses.
package gpu_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int FB_ADDR_W = 17;
    localparam int PIXEL_W   = 8;
    localparam int X_W       = 9;
    localparam int Y_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_FILL,
        ST_DONE
    } rect_fill_state_t;

    // Multiply by a constant width as a sum of shifted copies; with a fixed width
    // this reduces to a few adders (row<<8 + row<<6 for 320).
    function automatic logic [FB_ADDR_W-1:0] shiftAddMul(input logic [Y_W-1:0] row,
                                                          input logic [FB_ADDR_W-1:0] width);
        logic [FB_ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < FB_ADDR_W; i++) begin
            if (width[i]) begin
                acc = acc + (FB_ADDR_W'(row) << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/rect_fill.sv
// Rectangle fill engine: takes a corner-pair command and writes one pixel per cycle
// into a linear frame buffer, row-major, with the command's colour.
module rect_fill #(
    parameter int FB_WIDTH  = gpu_pkg::FB_WIDTH,
    parameter int FB_HEIGHT = gpu_pkg::FB_HEIGHT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [gpu_pkg::X_W-1:0]       cmd_x0,
    input  logic [gpu_pkg::X_W-1:0]       cmd_x1,
    input  logic [gpu_pkg::Y_W-1:0]       cmd_y0,
    input  logic [gpu_pkg::Y_W-1:0]       cmd_y1,
    input  logic [gpu_pkg::PIXEL_W-1:0]   cmd_color,
    output logic                          fb_we,
    output logic [gpu_pkg::FB_ADDR_W-1:0] fb_addr,
    output logic [gpu_pkg::PIXEL_W-1:0]   fb_data,
    output logic                          busy,
    output logic                          done
);
    import gpu_pkg::*;

    localparam logic [X_W-1:0]       X_LAST   = X_W'(FB_WIDTH - 1);
    localparam logic [Y_W-1:0]       Y_LAST   = Y_W'(FB_HEIGHT - 1);
    localparam logic [FB_ADDR_W-1:0] ROW_STEP = FB_ADDR_W'(FB_WIDTH);

    rect_fill_state_t     state_q;
    logic [X_W-1:0]       cmdX0_q, cmdX1_q;
    logic [Y_W-1:0]       cmdY0_q, cmdY1_q;
    logic [PIXEL_W-1:0]   color_q;
    logic [X_W-1:0]       xMin_q, xMax_q, x_q;
    logic [Y_W-1:0]       yMax_q, y_q;
    logic [FB_ADDR_W-1:0] rowBase_q, addr_q;
    logic                 we_q, done_q, busy_q, ready_q;

    logic [X_W-1:0]       xMin_d, xMax_d;
    logic [Y_W-1:0]       yMin_d, yMax_d;
    logic [FB_ADDR_W-1:0] rowBase_d;

    // Corner ordering and clamping only matter in SETUP, where the results are latched.
    always_comb begin
        xMin_d = (cmdX0_q < cmdX1_q) ? cmdX0_q : cmdX1_q;
        xMax_d = (cmdX0_q < cmdX1_q) ? cmdX1_q : cmdX0_q;
        yMin_d = (cmdY0_q < cmdY1_q) ? cmdY0_q : cmdY1_q;
        yMax_d = (cmdY0_q < cmdY1_q) ? cmdY1_q : cmdY0_q;
        if (xMin_d > X_LAST) xMin_d = X_LAST;
        if (xMax_d > X_LAST) xMax_d = X_LAST;
        if (yMin_d > Y_LAST) yMin_d = Y_LAST;
        if (yMax_d > Y_LAST) yMax_d = Y_LAST;
        rowBase_d = shiftAddMul(yMin_d, ROW_STEP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cmdX0_q   <= '0;
            cmdX1_q   <= '0;
            cmdY0_q   <= '0;
            cmdY1_q   <= '0;
            color_q   <= '0;
            xMin_q    <= '0;
            xMax_q    <= '0;
            x_q       <= '0;
            yMax_q    <= '0;
            y_q       <= '0;
            rowBase_q <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && ready_q) begin
                        cmdX0_q <= cmd_x0;
                        cmdX1_q <= cmd_x1;
                        cmdY0_q <= cmd_y0;
                        cmdY1_q <= cmd_y1;
                        color_q <= cmd_color;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    xMin_q    <= xMin_d;
                    xMax_q    <= xMax_d;
                    yMax_q    <= yMax_d;
                    x_q       <= xMin_d;
                    y_q       <= yMin_d;
                    rowBase_q <= rowBase_d;
                    addr_q    <= rowBase_d + FB_ADDR_W'(xMin_d);
                    we_q      <= 1'b1;
                    state_q   <= ST_FILL;
                end
                // Each FILL cycle presents the pixel at (x_q, y_q) and prepares the next one.
                ST_FILL: begin
                    if (x_q == xMax_q) begin
                        if (y_q == yMax_q) begin
                            we_q    <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            x_q       <= xMin_q;
                            y_q       <= y_q + 8'd1;
                            rowBase_q <= rowBase_q + ROW_STEP;
                            addr_q    <= rowBase_q + ROW_STEP + FB_ADDR_W'(xMin_q);
                        end
                    end else begin
                        x_q    <= x_q + 9'd1;
                        addr_q <= addr_q + 17'd1;
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    we_q    <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fb_we     = we_q;
    assign fb_addr   = addr_q;
    assign fb_data   = color_q;

endmodule

// File: tb/tb_rect_fill.sv
// Self-checking bench for rect_fill: directed corner cases plus random rectangles
// compared against a plain nested-loop model of the fill.
module tb_rect_fill;

    localparam int W = 320;
    localparam int H = 240;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_x0, cmd_x1;
    logic [7:0]  cmd_y0, cmd_y1, cmd_color;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [7:0]  fb_data;
    logic        busy, done;

    int compared = 0;
    int mismatched = 0;
    int cycleCount = 0;
    int logAddr[$];
    int logData[$];
    int logCycle[$];
    int expAddr[$];
    int expData[$];
    int doneCycleQ[$];
    int busyCycles = 0;
    int readyWhileBusy = 0;

    rect_fill dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
        .cmd_color(cmd_color), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // A write seen here commits to the frame buffer on the following rising edge.
    always @(negedge clk) begin
        if (fb_we) begin
            logAddr.push_back(int'(fb_addr));
            logData.push_back(int'(fb_data));
            logCycle.push_back(cycleCount);
        end
        if (busy) busyCycles++;
        if (done) doneCycleQ.push_back(cycleCount);
        if (busy && cmd_ready) readyWhileBusy++;
    end

    // Reference: order, clamp, then enumerate pixels row by row.
    function automatic void appendExpected(input int x0, input int x1, input int y0,
                                           input int y1, input int color);
        int xl = (x0 < x1) ? x0 : x1;
        int xh = (x0 < x1) ? x1 : x0;
        int yl = (y0 < y1) ? y0 : y1;
        int yh = (y0 < y1) ? y1 : y0;
        if (xl > W - 1) xl = W - 1;
        if (xh > W - 1) xh = W - 1;
        if (yl > H - 1) yl = H - 1;
        if (yh > H - 1) yh = H - 1;
        for (int y = yl; y <= yh; y++) begin
            for (int x = xl; x <= xh; x++) begin
                expAddr.push_back(y * W + x);
                expData.push_back(color);
            end
        end
    endfunction

    function automatic int firstDiff();
        int n = (logAddr.size() < expAddr.size()) ? logAddr.size() : expAddr.size();
        for (int i = 0; i < n; i++) begin
            if (logAddr[i] != expAddr[i] || logData[i] != expData[i]) return i;
        end
        if (logAddr.size() != expAddr.size()) return n;
        return -1;
    endfunction

    task automatic startCapture();
        logAddr.delete();
        logData.delete();
        logCycle.delete();
        expAddr.delete();
        expData.delete();
        doneCycleQ.delete();
        busyCycles = 0;
        readyWhileBusy = 0;
    endtask

    task automatic issue(input int x0, input int x1, input int y0, input int y1,
                         input int color, output int acceptCycle);
        int n = 0;
        @(negedge clk);
        cmd_x0 = 9'(x0);
        cmd_x1 = 9'(x1);
        cmd_y0 = 8'(y0);
        cmd_y1 = 8'(y1);
        cmd_color = 8'(color);
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        acceptCycle = cycleCount;
    endtask

    task automatic waitIdle(input int budget, output bit timedOut);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        timedOut = busy;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        compared++;
        if (fb_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_ctrl: we/done/busy/ready = %b%b%b%b, expected 0001",
                     fb_we, done, busy, cmd_ready);
        end
        compared++;
        if (fb_addr !== 17'd0 || fb_data !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: addr=%0d data=%0h, expected 0 and 0", fb_addr, fb_data);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_pixel();
        int acc;
        bit to;
        startCapture();
        appendExpected(5, 5, 7, 7, 8'h3C);
        issue(5, 5, 7, 7, 8'h3C, acc);
        waitIdle(50, to);
        compared++;
        if (to || logAddr.size() != 1 || logAddr[0] != 2245 || logData[0] != 8'h3C) begin
            mismatched++;
            $display("[TB] FAIL single_write: %0d writes (timeout=%0d), expected one write at 2245 data 3c",
                     logAddr.size(), to);
        end
        compared++;
        if (busyCycles != 3) begin
            mismatched++;
            $display("[TB] FAIL single_busy: busy %0d cycles, expected 3", busyCycles);
        end
        if (logCycle.size() > 0 && doneCycleQ.size() > 0) begin
            compared++;
            if (doneCycleQ[0] != logCycle[0] + 1) begin
                mismatched++;
                $display("[TB] FAIL single_done: done at cycle %0d, expected %0d",
                         doneCycleQ[0], logCycle[0] + 1);
            end
            compared++;
            if (logCycle[0] + 1 - acc != 2) begin
                mismatched++;
                $display("[TB] FAIL single_latency: write commits %0d edges after accept, expected 2",
                         logCycle[0] + 1 - acc);
            end
        end else begin
            compared++;
            mismatched++;
            $display("[TB] FAIL single_events: writes=%0d dones=%0d, expected 1 and 1",
                     logCycle.size(), doneCycleQ.size());
        end
    endtask

    task automatic test_swapped();
        int acc;
        bit to;
        int fd;
        startCapture();
        expAddr = '{0, 1, 2, 320, 321, 322};
        expData = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
        issue(2, 0, 1, 0, 8'hAA, acc);
        waitIdle(50, to);
        fd = firstDiff();
        compared++;
        if (to || fd != -1) begin
            mismatched++;
            $display("[TB] FAIL swapped_writes: first diff at %0d of %0d logged, expected 6 matching",
                     fd, logAddr.size());
        end
        compared++;
        if (busyCycles != 8 || doneCycleQ.size() != 1) begin
            mismatched++;
            $display("[TB] FAIL swapped_busy: busy=%0d dones=%0d, expected 8 and 1",
                     busyCycles, doneCycleQ.size());
        end
    endtask

    task automatic test_clamp();
        int acc;
        bit to;
        int fd;
        int maxAddr = 0;
        startCapture();
        expAddr = '{76478, 76479, 76798, 76799};
        expData = '{8'h55, 8'h55, 8'h55, 8'h55};
        // 255 is the largest row the 8-bit port can carry; it clamps like any larger value.
        issue(318, 400, 238, 255, 8'h55, acc);
        waitIdle(50, to);
        fd = firstDiff();
        compared++;
        if (to || fd != -1) begin
            mismatched++;
            $display("[TB] FAIL clamp_writes: first diff at %0d of %0d logged, expected 4 matching",
                     fd, logAddr.size());
        end
        foreach (logAddr[i]) if (logAddr[i] > maxAddr) maxAddr = logAddr[i];
        compared++;
        if (maxAddr > 76799) begin
            mismatched++;
            $display("[TB] FAIL clamp_max: highest addr %0d, expected <= 76799", maxAddr);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            int xa = $urandom_range(0, 325);
            int xb = xa + $urandom_range(0, 5);
            int ya = $urandom_range(0, 245);
            int yb = ya + $urandom_range(0, 4);
            int col = $urandom_range(0, 255);
            int acc;
            bit to;
            int fd;
            int expBusy;
            if ($urandom_range(0, 1) == 1) begin
                int t = xa; xa = xb; xb = t;
            end
            if ($urandom_range(0, 1) == 1) begin
                int t = ya; ya = yb; yb = t;
            end
            startCapture();
            appendExpected(xa, xb, ya, yb, col);
            expBusy = expAddr.size() + 2;
            issue(xa, xb, ya, yb, col, acc);
            waitIdle(200, to);
            fd = firstDiff();
            compared++;
            if (to || fd != -1) begin
                mismatched++;
                $display("[TB] FAIL random_writes[%0d] (%0d,%0d)-(%0d,%0d): diff at %0d, logged %0d expected %0d",
                         k, xa, ya, xb, yb, fd, logAddr.size(), expAddr.size());
            end
            compared++;
            if (busyCycles != expBusy) begin
                mismatched++;
                $display("[TB] FAIL random_busy[%0d]: busy %0d cycles, expected %0d", k, busyCycles, expBusy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int readyCycle;
        bit to;
        int fd;
        startCapture();
        appendExpected(3, 6, 10, 11, 8'h11);
        appendExpected(100, 98, 50, 52, 8'h22);
        @(negedge clk);
        cmd_x0 = 9'd3; cmd_x1 = 9'd6; cmd_y0 = 8'd10; cmd_y1 = 8'd11; cmd_color = 8'h11;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_x0 = 9'd100; cmd_x1 = 9'd98; cmd_y0 = 8'd50; cmd_y1 = 8'd52; cmd_color = 8'h22;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 200);
        readyCycle = cycleCount;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        waitIdle(200, to);
        fd = firstDiff();
        compared++;
        if (to || fd != -1) begin
            mismatched++;
            $display("[TB] FAIL b2b_writes: diff at %0d, logged %0d expected %0d",
                     fd, logAddr.size(), expAddr.size());
        end
        compared++;
        if (readyWhileBusy != 0 || doneCycleQ.size() != 2) begin
            mismatched++;
            $display("[TB] FAIL b2b_ready: ready-while-busy=%0d dones=%0d, expected 0 and 2",
                     readyWhileBusy, doneCycleQ.size());
        end
        if (doneCycleQ.size() > 0) begin
            compared++;
            if (readyCycle - doneCycleQ[0] != 1) begin
                mismatched++;
                $display("[TB] FAIL b2b_accept: ready %0d cycles after done, expected 1",
                         readyCycle - doneCycleQ[0]);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        int acc;
        int n = 0;
        int fd;
        startCapture();
        appendExpected(0, 99, 0, 0, 8'hFF);
        issue(0, 319, 0, 239, 8'hFF, acc);
        while (logAddr.size() < 100 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        compared++;
        if (logAddr.size() != 100) begin
            mismatched++;
            $display("[TB] FAIL rstfill_reach: %0d writes before reset point, expected 100", logAddr.size());
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        compared++;
        if (fb_we !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rstfill_stop: we=%b busy=%b, expected 0 0", fb_we, busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        fd = firstDiff();
        compared++;
        if (fd != -1) begin
            mismatched++;
            $display("[TB] FAIL rstfill_log: diff at %0d, logged %0d writes, expected 100",
                     fd, logAddr.size());
        end
        compared++;
        if (cmd_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rstfill_ready: cmd_ready=%b, expected 1", cmd_ready);
        end
    endtask

    task automatic test_full_screen();
        int acc;
        bit to;
        int fd;
        startCapture();
        appendExpected(0, 319, 0, 239, 8'hFF);
        issue(0, 319, 0, 239, 8'hFF, acc);
        waitIdle(77000, to);
        fd = firstDiff();
        compared++;
        if (to || fd != -1) begin
            mismatched++;
            $display("[TB] FAIL full_writes: diff at %0d, logged %0d expected 76800 (timeout=%0d)",
                     fd, logAddr.size(), to);
        end
        compared++;
        if (logAddr.size() == 0 || logAddr[logAddr.size() - 1] != 76799) begin
            mismatched++;
            $display("[TB] FAIL full_last: last addr %0d, expected 76799",
                     (logAddr.size() == 0) ? -1 : logAddr[logAddr.size() - 1]);
        end
        compared++;
        if (busyCycles != 76802) begin
            mismatched++;
            $display("[TB] FAIL full_busy: busy %0d cycles, expected 76802", busyCycles);
        end
        compared++;
        if (logCycle.size() != 76800 || logCycle[76799] - logCycle[0] != 76799) begin
            mismatched++;
            $display("[TB] FAIL full_consecutive: %0d writes not on consecutive cycles", logCycle.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0; cmd_color = '0;
        test_reset();
        test_single_pixel();
        test_swapped();
        test_clamp();
        test_random();
        test_back_to_back();
        test_reset_mid_fill();
        test_full_screen();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
